// File: rtl/button_events.sv
// Button event decoder: turns a debounced level into press/release, long-press,
// auto-repeat and double-tap pulses, all registered with one cycle of latency.
module button_events #(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned DTAP_CYCLES   = 25_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clean_i,
  output logic press_o,
  output logic release_o,
  output logic long_press_o,
  output logic repeat_tick_o,
  output logic double_tap_o,
  output logic held_o
);

  localparam int unsigned MaxHR     = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned MaxCycles = (MaxHR > DTAP_CYCLES) ? MaxHR : DTAP_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

  // Terminal counts: the counter starts at 0 the cycle after entry, so N cycles ends at N-1.
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] RepLast  = CntW'(REPEAT_CYCLES - 1);
  localparam logic [CntW-1:0] DtapLast = CntW'(DTAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StDown, StRepeat, StUpWait} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              prev_q;
  logic              dt_used_q;
  logic              press_q, release_q, long_press_q, repeat_tick_q, double_tap_q, held_q;
  logic              rise, fall;

  assign rise = clean_i & ~prev_q;
  assign fall = ~clean_i & prev_q;

  always_ff @(posedge clk_i) begin
    prev_q        <= clean_i;
    press_q       <= 1'b0;
    release_q     <= 1'b0;
    long_press_q  <= 1'b0;
    repeat_tick_q <= 1'b0;
    double_tap_q  <= 1'b0;
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      dt_used_q <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (rise) begin
            press_q <= 1'b1;
            held_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= StDown;
          end
        end
        StDown: begin
          // A fall wins over a long press due in the same cycle.
          if (fall) begin
            release_q <= 1'b1;
            held_q    <= 1'b0;
            cnt_q     <= '0;
            if (dt_used_q) begin
              dt_used_q <= 1'b0;
              state_q   <= StIdle;
            end else begin
              state_q <= StUpWait;
            end
          end else if (cnt_q == HoldLast) begin
            long_press_q <= 1'b1;
            cnt_q        <= '0;
            state_q      <= StRepeat;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRepeat: begin
          if (fall) begin
            release_q <= 1'b1;
            held_q    <= 1'b0;
            cnt_q     <= '0;
            dt_used_q <= 1'b0;
            state_q   <= StIdle;
          end else if (cnt_q == RepLast) begin
            repeat_tick_q <= 1'b1;
            cnt_q         <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StUpWait: begin
          // A rise on the last window cycle still counts as a double tap.
          if (rise) begin
            press_q      <= 1'b1;
            double_tap_q <= 1'b1;
            dt_used_q    <= 1'b1;
            held_q       <= 1'b1;
            cnt_q        <= '0;
            state_q      <= StDown;
          end else if (cnt_q == DtapLast) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_q   <= '0;
          held_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign press_o       = press_q;
  assign release_o     = release_q;
  assign long_press_o  = long_press_q;
  assign repeat_tick_o = repeat_tick_q;
  assign double_tap_o  = double_tap_q;
  assign held_o        = held_q;

endmodule

// File: doc/button_events.md
BUTTON_EVENTS -- requirements
Module: button_events

Interface
REQ-001 Parameter HOLD_CYCLES, default 50_000_000: press duration in clock cycles, measured from the press pulse, that qualifies as a long press (500 ms at 10 ns).
REQ-002 Parameter REPEAT_CYCLES, default 10_000_000: auto-repeat period in cycles after a long press.
REQ-003 Parameter DTAP_CYCLES, default 25_000_000: window in cycles after a release in which a new press counts as a double tap.
REQ-004 clk  input  1  system clock; all logic on posedge clk.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 clean  input  1  debounced button level, already synchronous to clk; 1 = pressed.
REQ-007 press  output  1  one-cycle pulse on each press.
REQ-008 release  output  1  one-cycle pulse on each release.
REQ-009 long_press  output  1  one-cycle pulse when a press reaches HOLD_CYCLES.
REQ-010 repeat_tick  output  1  one-cycle pulse every REPEAT_CYCLES while a long press continues.
REQ-011 double_tap  output  1  one-cycle pulse on a qualifying second press.
REQ-012 held  output  1  level; 1 while the FSM is in DOWN or REPEAT.

Function
REQ-013 Block SHALL register clean into prev every cycle; a rise is clean=1 with prev=0, and a fall is clean=0 with prev=1.
REQ-014 All outputs SHALL be registered; each pulse SHALL be high in the cycle after the posedge that detects its cause, giving latency 1.
REQ-015 FSM SHALL have exactly these states: IDLE, DOWN, REPEAT, UP_WAIT.
REQ-016 A rise in IDLE or UP_WAIT SHALL assert press, enter DOWN, and clear the shared counter to 0.
REQ-017 In DOWN, the counter SHALL increment each cycle; long_press SHALL assert exactly HOLD_CYCLES cycles after press; the FSM SHALL then enter REPEAT with counter 0.
REQ-018 In REPEAT, repeat_tick SHALL assert every REPEAT_CYCLES cycles, with the first tick REPEAT_CYCLES cycles after long_press.
REQ-019 A fall in DOWN or REPEAT SHALL assert release; a fall takes priority over a long_press or repeat_tick due in the same cycle, and the suppressed pulse SHALL not assert.
REQ-020 A fall from DOWN SHALL enter UP_WAIT with counter 0 only if flag dt_used=0; otherwise it SHALL go to IDLE and clear dt_used.
REQ-021 A fall from REPEAT SHALL go to IDLE and clear dt_used, so long presses never open a double-tap window.
REQ-022 In UP_WAIT, a rise no later than DTAP_CYCLES cycles after the release pulse SHALL assert press and double_tap in the same cycle and set dt_used=1, so taps do not chain beyond a pair.
REQ-023 UP_WAIT with no rise SHALL return to IDLE after exactly DTAP_CYCLES cycles.
REQ-024 Counter width SHALL be $clog2 of the largest parameter plus 1; the counter SHALL never wrap within a state.
REQ-025 At most one of press and release SHALL assert per cycle; long_press and repeat_tick SHALL never coincide.

Reset
REQ-026 While rst=1, state SHALL be IDLE, counter 0, dt_used 0, and all outputs 0; prev SHALL load the current clean.
REQ-027 A button held through reset SHALL produce no press until it has been sampled 0 and then 1.
REQ-028 rst asserted mid-press or mid-window SHALL abort without emitting release or any other pulse.

Verification (HOLD_CYCLES=20, REPEAT_CYCLES=5, DTAP_CYCLES=10)
REQ-029 Short tap: clean high for 8 cycles -> press once, release once 8 cycles later, held high for 8 cycles, and no long_press.
REQ-030 Long hold: clean high for 37 cycles -> long_press 20 cycles after press, repeat_tick at +25, +30 and +35, then release.
REQ-031 Double tap: a 5-cycle tap, then low for 6 cycles, then a 5-cycle tap -> second press coincides with double_tap; a third tap 4 cycles later gives press only.
REQ-032 Window expiry: a 5-cycle tap, then low for 12 cycles, then a tap -> no double_tap.
REQ-033 Fall on the same cycle long_press is due (clean high exactly 20 cycles) -> release only, with long_press never asserted.
REQ-034 Reset: clean=1 during rst, then held for 30 cycles after rst falls -> no pulses; a following 0→1 gives press.
